// File: rtl/demux1to4_buf_pkg.sv
// demux1to4_buf_pkg: shared channel count, select width, pointer-width and channel-offset helpers
package demux1to4_buf_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int ch_off(input int k, input int width);
    return k * width;
  endfunction
endpackage

// File: rtl/demux1to4_buf_chan_fifo.sv
// chan_fifo: DEPTH-entry sync FIFO (clk, rst_n, push/din in, pop in, full/empty/head out); push when full and pop when empty are ignored
module chan_fifo
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push_e, pop_e;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_e = push & ~full;
  assign pop_e = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_e) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push_e ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_e ? rd_ptr + 1'b1 : rd_ptr;
      count <= (push_e & ~pop_e) ? count + 1'b1 : (~push_e & pop_e) ? count - 1'b1 : count;
    end
endmodule

// File: rtl/demux1to4_buf.sv
// demux1to4_buf: registered 1-to-4 demux (in_data/in_sel/in_valid -> in_ready; four FIFOs -> out_data/out_valid, out_ready), async active-low rst_n
module demux1to4_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready
);
  logic [NUM_CH-1:0] full, empty, push;
  logic [WIDTH-1:0] head [NUM_CH];
  assign in_ready = rst_n & ~full[in_sel];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = in_valid & in_ready & (in_sel == SEL_W'(k));
    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push[k]),
      .pop(out_ready[k]),
      .din(in_data),
      .full(full[k]),
      .empty(empty[k]),
      .head(head[k])
    );
    assign out_valid[k] = ~empty[k];
    assign out_data[ch_off(k, WIDTH) +: WIDTH] = empty[k] ? '0 : head[k];
  end
endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf: randomized and directed check of demux1to4_buf against per-channel queue model
module tb_demux1to4_buf;
  localparam int W = 8;
  localparam int D = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic [W-1:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic in_valid = 0;
  logic in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  int vectors = 0;
  int errors = 0;
  logic [W-1:0] q [4][$];
  always #5 clk = ~clk;
  demux1to4_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic [3:0] ev;
    logic [4*W-1:0] ed;
    ev = '0;
    ed = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = q[k].size() != 0;
      if (ev[k]) ed[k*W +: W] = q[k][0];
    end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rst_n && q[in_sel].size() < D));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_data"}, 64'(out_data), 64'(ed));
  endtask
  task automatic cycle(input string tag);
    logic [3:0] pop;
    bit pu;
    @(negedge clk);
    check_all(tag);
    for (int k = 0; k < 4; k++) pop[k] = rst_n && out_ready[k] && q[k].size() != 0;
    pu = rst_n && in_valid && q[in_sel].size() < D;
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (pop[k]) void'(q[k].pop_front());
    if (pu) q[in_sel].push_back(in_data);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
  endtask
  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), W'($urandom), 4'($urandom & $urandom));
      cycle("rand");
    end
  endtask
  initial begin
    drive(1, 0, 8'h99, 4'hf);
    for (int i = 0; i < 3; i++) begin
      cycle("reset");
      chk("reset.in_ready", 64'(in_ready), 64'(0));
      chk("reset.out_valid", 64'(out_valid), 64'(0));
    end
    rst_n = 1;
    drive(0, 3, 0, 0);
    #2 chk("release.in_ready", 64'(in_ready), 64'(1));
    cycle("release");
    drive(1, 2, 8'hA5, 0);
    cycle("route");
    drive(0, 0, 0, 0);
    chk("route.out_valid", 64'(out_valid), 64'(4'b0100));
    chk("route.out_data", 64'(out_data), 64'(32'h00A5_0000));
    cycle("route_hold");
    drive(0, 0, 0, 4'b0100);
    cycle("route_pop");
    drive(1, 1, 8'h11, 0);
    cycle("fill");
    drive(1, 1, 8'h22, 0);
    cycle("fill");
    drive(1, 1, 8'h33, 0);
    chk("stall.in_ready", 64'(in_ready), 64'(0));
    cycle("stall");
    out_ready = 4'b0010;
    chk("nobypass.in_ready", 64'(in_ready), 64'(0));
    cycle("stall_pop");
    out_ready = 4'b0000;
    chk("after_pop.in_ready", 64'(in_ready), 64'(1));
    chk("after_pop.head", 64'(out_data[15:8]), 64'(8'h22));
    cycle("accept33");
    drive(0, 0, 0, 4'b0010);
    chk("order.head22", 64'(out_data[15:8]), 64'(8'h22));
    cycle("drain");
    chk("order.head33", 64'(out_data[15:8]), 64'(8'h33));
    cycle("drain");
    chk("drain.out_valid", 64'(out_valid), 64'(0));
    drive(1, 0, 8'h61, 0);
    cycle("fill0");
    drive(1, 0, 8'h62, 0);
    cycle("fill0");
    drive(1, 0, 8'h77, 4'b0001);
    chk("full_pop.in_ready", 64'(in_ready), 64'(0));
    cycle("full_pop");
    chk("full_pop.next_ready", 64'(in_ready), 64'(1));
    drive(0, 0, 0, 4'b0001);
    cycle("drain0");
    cycle("drain0");
    drive(1, 3, 8'h44, 0);
    cycle("conc_pre");
    drive(1, 0, 8'h0A, 0);
    cycle("conc_pre");
    drive(1, 1, 8'h1B, 0);
    cycle("conc_pre");
    drive(1, 3, 8'h5A, 4'b1011);
    cycle("conc");
    drive(0, 0, 0, 0);
    chk("conc.out_valid", 64'(out_valid), 64'(4'b1000));
    chk("conc.head3", 64'(out_data[31:24]), 64'(8'h5A));
    cycle("conc_hold");
    drive(0, 0, 0, 4'b1000);
    cycle("conc_drain");
    rand_run(600);
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), 8'hC0 + 8'(k), 0);
      cycle("prefill");
    end
    drive(0, 0, 0, 0);
    #2 rst_n = 0;
    for (int k = 0; k < 4; k++) q[k].delete();
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'(0));
    chk("async_rst.out_data", 64'(out_data), 64'(0));
    chk("async_rst.in_ready", 64'(in_ready), 64'(0));
    cycle("in_reset");
    cycle("in_reset");
    rst_n = 1;
    drive(0, 0, 0, 4'hf);
    cycle("post_rst");
    chk("post_rst.out_valid", 64'(out_valid), 64'(0));
    rand_run(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
